// File: rtl/vga_timing_if.sv
// Video timing bundle between the timing generator (master) and a pixel consumer (slave).
// The consumer drives the pixel-advance enable; the generator returns position, syncs and strobes.
interface vga_timing_if;
   logic        ce;
   logic [10:0] xpos;
   logic [10:0] ypos;
   logic        hsync;
   logic        vsync;
   logic        disp_active;
   logic        newline;
   logic        newframe;

   modport master (
      input  ce,
      output xpos, ypos, hsync, vsync, disp_active, newline, newframe
   );

   modport slave (
      output ce,
      input  xpos, ypos, hsync, vsync, disp_active, newline, newframe
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: 11-bit pixel/line counters with registered, zero-skew decode
// of syncs, visible area and end-of-line/end-of-frame strobes.
module vga_timing_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 56,
   parameter int H_SYNC   = 120,
   parameter int H_BP     = 64,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 37,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 23,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   vga_timing_if.master vif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
       H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_param_err
      $error("vga_timing_gen: illegal timing parameters");
   end

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [10:0] x_q, x_d;
   logic [10:0] y_q, y_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        de_q, de_d;
   logic        line_tc_q, line_tc_d;
   logic        frame_tc_q, frame_tc_d;

   // Decode is taken from the next position so every registered output lines up with x_q/y_q.
   always_comb begin
      x_d        = x_q;
      y_d        = y_q;
      hs_d       = hs_q;
      vs_d       = vs_q;
      de_d       = de_q;
      line_tc_d  = line_tc_q;
      frame_tc_d = frame_tc_q;
      if (vif.ce) begin
         if (x_q == H_LAST) begin
            x_d = 11'd0;
            y_d = (y_q == V_LAST) ? 11'd0 : y_q + 11'd1;
         end else begin
            x_d = x_q + 11'd1;
         end
         de_d       = (x_d < H_ACT) && (y_d < V_ACT);
         hs_d       = ((x_d >= HS_START) && (x_d < HS_END)) ? HS_POL : ~HS_POL;
         vs_d       = ((y_d >= VS_START) && (y_d < VS_END)) ? VS_POL : ~VS_POL;
         line_tc_d  = (x_d == H_LAST);
         frame_tc_d = (x_d == H_LAST) && (y_d == V_LAST);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q        <= H_LAST;
         y_q        <= V_LAST;
         hs_q       <= ~HS_POL;
         vs_q       <= ~VS_POL;
         de_q       <= 1'b0;
         line_tc_q  <= 1'b1;
         frame_tc_q <= 1'b1;
      end else begin
         x_q        <= x_d;
         y_q        <= y_d;
         hs_q       <= hs_d;
         vs_q       <= vs_d;
         de_q       <= de_d;
         line_tc_q  <= line_tc_d;
         frame_tc_q <= frame_tc_d;
      end
   end

   assign vif.xpos        = x_q;
   assign vif.ypos        = y_q;
   assign vif.hsync       = hs_q;
   assign vif.vsync       = vs_q;
   assign vif.disp_active = de_q;
   // Strobes are qualified by ce and forced low while reset is held.
   assign vif.newline     = line_tc_q & vif.ce & rst_n;
   assign vif.newframe    = frame_tc_q & vif.ce & rst_n;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: three generators (small, small inverted polarity, default) against a
// position-from-ce-count arithmetic model, plus directed literal checks.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ce = 1'b0;

   always #5 clk = ~clk;

   vga_timing_if if_a ();
   vga_timing_if if_b ();
   vga_timing_if if_c ();

   assign if_a.ce = ce;
   assign if_b.ce = ce;
   assign if_c.ce = ce;

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1))
      u_a (.clk(clk), .rst_n(rst_n), .vif(if_a.master));

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .HS_POL(1'b0), .VS_POL(1'b0))
      u_b (.clk(clk), .rst_n(rst_n), .vif(if_b.master));

   vga_timing_gen u_c (.clk(clk), .rst_n(rst_n), .vif(if_c.master));

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic        hs;
      logic        vs;
      logic        de;
      logic        nl;
      logic        nf;
   } vout_t;

   vout_t act_a, act_b, act_c;
   assign act_a = {if_a.xpos, if_a.ypos, if_a.hsync, if_a.vsync, if_a.disp_active, if_a.newline, if_a.newframe};
   assign act_b = {if_b.xpos, if_b.ypos, if_b.hsync, if_b.vsync, if_b.disp_active, if_b.newline, if_b.newframe};
   assign act_c = {if_c.xpos, if_c.ypos, if_c.hsync, if_c.vsync, if_c.disp_active, if_c.newline, if_c.newframe};

   // Reference: after k ce-qualified edges since reset the raster index is (k-1) mod total.
   function automatic vout_t model(input longint k, input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input bit hp, input bit vp, input bit cen, input bit rn);
      vout_t  m;
      int     ht, vt, x, y;
      longint n, lin;
      ht  = ha + hf + hsw + hb;
      vt  = va + vf + vsw + vb;
      n   = longint'(ht) * longint'(vt);
      lin = (k + n - 1) % n;
      x   = int'(lin % ht);
      y   = int'(lin / ht);
      m.x  = 11'(x);
      m.y  = 11'(y);
      m.hs = (x >= ha + hf && x < ha + hf + hsw) ? hp : ~hp;
      m.vs = (y >= va + vf && y < va + vf + vsw) ? vp : ~vp;
      m.de = (x < ha) && (y < va);
      m.nl = (x == ht - 1) && cen && rn;
      m.nf = (x == ht - 1) && (y == vt - 1) && cen && rn;
      return m;
   endfunction

   longint k;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)  k <= 0;
      else if (ce) k <= k + 1;
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic check_out(input string nm, input vout_t act, input vout_t exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual x=%0d y=%0d hs=%b vs=%b de=%b nl=%b nf=%b required x=%0d y=%0d hs=%b vs=%b de=%b nl=%b nf=%b",
                    nm, act.x, act.y, act.hs, act.vs, act.de, act.nl, act.nf,
                    exp.x, exp.y, exp.hs, exp.vs, exp.de, exp.nl, exp.nf);
   endtask

   task automatic check_lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
   endtask

   always @(negedge clk) begin
      check_out("model_small", act_a, model(k, 8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1, ce, rst_n));
      check_out("model_inv",   act_b, model(k, 8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b0, ce, rst_n));
      check_out("model_dflt",  act_c, model(k, 800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1, ce, rst_n));
   end

   int  last_nf, nf_seen, last_nl, nl_seen, hs_start, hs_run, nlc;
   bit  prev_hs, hs_done, found;

   initial begin
      // Reset held with ce high: strobes must stay low.
      ce = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_lit("rst_x", 32'(if_a.xpos), 15);
      check_lit("rst_y", 32'(if_a.ypos), 7);
      check_lit("rst_nl", 32'(if_a.newline), 0);
      check_lit("rst_hs_inv", 32'(if_b.hsync), 1);
      check_lit("rst_dflt_x", 32'(if_c.xpos), 1039);
      ce = 1'b0;
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 ce = 1'b1;

      // Continuous ce: periods, first strobe, default-mode hsync window.
      last_nf = -1; nf_seen = 0; last_nl = -1; nl_seen = 0;
      prev_hs = 1'b0; hs_done = 1'b0; hs_start = 0; hs_run = 0;
      for (int cyc = 0; cyc < 3200; cyc++) begin
         @(negedge clk);
         if (cyc == 0) begin
            check_lit("first_nf", 32'(if_a.newframe), 1);
            check_lit("first_nl_dflt", 32'(if_c.newline), 1);
         end
         if (cyc == 1) begin
            check_lit("first_x0", 32'(if_a.xpos), 0);
            check_lit("first_de", 32'(if_a.disp_active), 1);
         end
         if (cyc == 11) check_lit("hs_x10", 32'(if_a.hsync), 1);
         if (if_a.newframe) begin
            if (last_nf >= 0 && nf_seen < 3) begin
               check_lit("nf_period", 32'(cyc - last_nf), 128);
               nf_seen++;
            end
            last_nf = cyc;
         end
         if (if_c.newline) begin
            if (last_nl >= 0 && nl_seen < 2) begin
               check_lit("nl_period_dflt", 32'(cyc - last_nl), 1040);
               nl_seen++;
            end
            last_nl = cyc;
         end
         if (if_c.hsync && !prev_hs) begin
            hs_start = int'(if_c.xpos);
            hs_run = 0;
         end
         if (if_c.hsync) hs_run++;
         if (!if_c.hsync && prev_hs && !hs_done) begin
            check_lit("hs_start_dflt", 32'(hs_start), 856);
            check_lit("hs_len_dflt", 32'(hs_run), 120);
            hs_done = 1'b1;
         end
         prev_hs = if_c.hsync;
      end
      check_lit("nf_count", 32'(nf_seen), 3);

      // Random ce gaps, checked by the model process.
      repeat (2000) begin
         @(posedge clk);
         #1 ce = 1'($urandom_range(0, 1));
      end

      // ce pattern 1,0,0,1 across x=15.
      ce = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (if_a.xpos == 11'd14) found = 1'b1;
      end
      check_lit("find_x14", 32'(found), 1);
      @(posedge clk);
      #1 ce = 1'b0;
      nlc = 0;
      repeat (2) begin
         @(negedge clk);
         check_lit("freeze_x", 32'(if_a.xpos), 15);
         if (if_a.newline) nlc++;
      end
      @(posedge clk);
      #1 ce = 1'b1;
      @(negedge clk);
      check_lit("nl_at_15", 32'(if_a.newline), 1);
      if (if_a.newline) nlc++;
      check_lit("nl_once", 32'(nlc), 1);

      // Asynchronous reset mid-frame at (5,2).
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (if_a.xpos == 11'd5 && if_a.ypos == 11'd2) found = 1'b1;
      end
      check_lit("find_x5y2", 32'(found), 1);
      #2 rst_n = 1'b0;
      #1;
      check_lit("arst_x", 32'(if_a.xpos), 15);
      check_lit("arst_y", 32'(if_a.ypos), 7);
      check_lit("arst_de", 32'(if_a.disp_active), 0);
      check_lit("arst_nf", 32'(if_a.newframe), 0);
      check_lit("arst_vs_inv", 32'(if_b.vsync), 1);
      ce = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1 ce = 1'b1;
      @(negedge clk);
      check_lit("post_nf", 32'(if_a.newframe), 1);
      check_lit("post_nl", 32'(if_a.newline), 1);
      @(negedge clk);
      check_lit("post_x", 32'(if_a.xpos), 0);
      check_lit("post_y", 32'(if_a.ypos), 0);
      check_lit("post_de", 32'(if_a.disp_active), 1);

      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
